// File: rtl/tlul_host_arb.sv
// tlul_host_arb: round-robin arbiter that shares one TL-UL device port among NumHosts hosts,
// with one transaction in flight at a time.
package tlul_pkg;
  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DBW = TL_DW / 8;
  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [1:0]        a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [1:0]        d_size;
    logic [TL_AIW-1:0] d_source;
    logic              d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;
endpackage

module tlul_host_arb #(
  parameter int NumHosts = 2,
  parameter int IdxW = $clog2(NumHosts)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  tlul_pkg::tl_h2d_t  host_tl_i [NumHosts],
  output tlul_pkg::tl_d2h_t  host_tl_o [NumHosts],
  output tlul_pkg::tl_h2d_t  dev_tl_o,
  input  tlul_pkg::tl_d2h_t  dev_tl_i,
  output logic [NumHosts-1:0] grant_o,
  output logic               busy_o
);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;
  state_e state_q;
  logic [IdxW-1:0] gnt_q, last_q, pick, idx;
  logic any_req;
  tlul_pkg::tl_h2d_t gnt_h2d;
  assign gnt_h2d = host_tl_i[gnt_q];
  assign busy_o = state_q != IDLE;
  assign grant_o = busy_o ? NumHosts'(1) << gnt_q : '0;
  // Descending scan so the requester nearest after last_q is the one left in pick.
  always_comb begin
    pick = '0;
    idx = '0;
    any_req = 1'b0;
    for (int k = NumHosts; k >= 1; k--) begin
      idx = IdxW'((int'(last_q) + k) % NumHosts);
      if (host_tl_i[idx].a_valid) begin
        pick = idx;
        any_req = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q <= '0;
      last_q <= IdxW'(NumHosts - 1);
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          gnt_q <= pick;
          state_q <= REQ;
        end
        REQ: if (!gnt_h2d.a_valid) begin
          state_q <= IDLE;
          last_q <= gnt_q;
        end else if (dev_tl_i.a_ready) begin
          state_q <= RSP;
        end
        RSP: if (dev_tl_i.d_valid && gnt_h2d.d_ready) begin
          state_q <= IDLE;
          last_q <= gnt_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  always_comb begin
    dev_tl_o = (state_q == REQ) ? gnt_h2d : '0;
    dev_tl_o.d_ready = (state_q == RSP) && gnt_h2d.d_ready;
    for (int i = 0; i < NumHosts; i++) begin
      host_tl_o[i] = (state_q == RSP && gnt_q == IdxW'(i)) ? dev_tl_i : '0;
      host_tl_o[i].a_ready = state_q == REQ && gnt_q == IdxW'(i) && dev_tl_i.a_ready;
    end
  end
endmodule

// File: tb/tb_tlul_host_arb.sv
// tb_tlul_host_arb: directed and randomized checks of the round-robin TL-UL arbiter
// against a transaction-level rotation model.
module tb_tlul_host_arb;
  import tlul_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst;
  tl_h2d_t host_i [N];
  tl_d2h_t host_o [N];
  tl_h2d_t dev_o;
  tl_d2h_t dev_i;
  logic [N-1:0] grant;
  logic busy;
  int checks = 0;
  int errors = 0;
  int m_last;
  always #5 clk = ~clk;
  tlul_host_arb #(.NumHosts(N)) dut (
    .clk_i(clk), .rst_i(rst), .host_tl_i(host_i), .host_tl_o(host_o),
    .dev_tl_o(dev_o), .dev_tl_i(dev_i), .grant_o(grant), .busy_o(busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int model_pick(input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) if (mask[(m_last + k) % N]) return (m_last + k) % N;
    return 0;
  endfunction
  task automatic set_req(input int h, input logic v, input logic [31:0] addr, input logic [7:0] src);
    host_i[h].a_valid = v;
    host_i[h].a_opcode = 3'd4;
    host_i[h].a_param = 3'd0;
    host_i[h].a_size = 2'd2;
    host_i[h].a_source = src;
    host_i[h].a_address = addr;
    host_i[h].a_mask = 4'hf;
    host_i[h].a_data = $urandom;
  endtask
  task automatic idle_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_dev_avalid"}, dev_o.a_valid, 0);
    chk({tag, "_dev_dready"}, dev_o.d_ready, 0);
    for (int j = 0; j < N; j++) begin
      chk({tag, "_h_aready"}, host_o[j].a_ready, 0);
      chk({tag, "_h_dvalid"}, host_o[j].d_valid, 0);
    end
  endtask
  task automatic do_reset;
    rst = 1'b1;
    for (int j = 0; j < N; j++) host_i[j] = '0;
    dev_i = '0;
    tick;
    tick;
    rst = 1'b0;
    m_last = N - 1;
  endtask
  // Starts in IDLE with requests already presented; h is the host expected to win.
  task automatic run_txn(input int h, input int a_lat, input int r_lat, input logic [31:0] rdata, input logic drop);
    tl_h2d_t req;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_dev_avalid", dev_o.a_valid, 0);
    tick;
    req = host_i[h];
    dev_i.a_ready = 1'b0;
    #1;
    chk("req_grant", grant, N'(1) << h);
    chk("req_dev_avalid", dev_o.a_valid, 1);
    chk("req_addr", dev_o.a_address, req.a_address);
    chk("req_source", dev_o.a_source, req.a_source);
    chk("req_opcode", dev_o.a_opcode, req.a_opcode);
    chk("req_data", dev_o.a_data, req.a_data);
    chk("req_dev_dready", dev_o.d_ready, 0);
    for (int r = 0; r < a_lat; r++) begin
      chk("bp_h_aready", host_o[h].a_ready, 0);
      tick;
      chk("bp_busy", busy, 1);
      chk("bp_dev_avalid", dev_o.a_valid, 1);
    end
    dev_i.a_ready = 1'b1;
    #1;
    chk("req_h_aready", host_o[h].a_ready, 1);
    for (int j = 0; j < N; j++) if (j != h) chk("req_other_aready", host_o[j].a_ready, 0);
    tick;
    dev_i.a_ready = 1'b0;
    if (drop) host_i[h].a_valid = 1'b0;
    dev_i.d_valid = 1'b1;
    dev_i.d_opcode = 3'd1;
    dev_i.d_data = rdata;
    dev_i.d_source = req.a_source;
    host_i[h].d_ready = 1'b0;
    #1;
    chk("rsp_dev_avalid", dev_o.a_valid, 0);
    chk("rsp_grant", grant, N'(1) << h);
    for (int r = 0; r < r_lat; r++) begin
      chk("rsp_dev_dready_hold", dev_o.d_ready, 0);
      chk("rsp_h_dvalid_hold", host_o[h].d_valid, 1);
      tick;
      chk("rsp_busy_hold", busy, 1);
    end
    host_i[h].d_ready = 1'b1;
    #1;
    chk("rsp_dev_dready", dev_o.d_ready, 1);
    chk("rsp_h_dvalid", host_o[h].d_valid, 1);
    chk("rsp_h_ddata", host_o[h].d_data, rdata);
    chk("rsp_h_dsource", host_o[h].d_source, req.a_source);
    for (int j = 0; j < N; j++) if (j != h) chk("rsp_other_dvalid", host_o[j].d_valid, 0);
    tick;
    dev_i.d_valid = 1'b0;
    host_i[h].d_ready = 1'b0;
    m_last = h;
    chk("post_busy", busy, 0);
  endtask
  initial begin
    logic [N-1:0] mask;
    int h;
    for (int j = 0; j < N; j++) host_i[j] = '0;
    dev_i = '0;
    do_reset;
    idle_zero("reset");
    // Stray device response while idle must not leak through.
    dev_i.d_valid = 1'b1;
    dev_i.d_data = 32'hDEAD_BEEF;
    for (int j = 0; j < N; j++) host_i[j].d_ready = 1'b1;
    #1;
    idle_zero("stray");
    tick;
    idle_zero("stray2");
    dev_i = '0;
    for (int j = 0; j < N; j++) host_i[j].d_ready = 1'b0;
    // Single host 1 Get to 0x40.
    set_req(1, 1'b1, 32'h40, 8'h21);
    run_txn(1, 0, 0, 32'hA5A5_0001, 1'b1);
    // Contention: all hosts continuously requesting, rotation from host 0.
    do_reset;
    for (int j = 0; j < N; j++) set_req(j, 1'b1, 32'h100 + 32'(j * 4), 8'(8'h10 + j));
    for (int t = 0; t < 8; t++) run_txn(t % N, 0, 0, $urandom, 1'b0);
    // Backpressure on both channels.
    do_reset;
    set_req(2, 1'b1, 32'h80, 8'h33);
    run_txn(2, 5, 3, 32'h1234_5678, 1'b1);
    // Abandoned request from host 0 hands priority onward to host 1.
    do_reset;
    set_req(0, 1'b1, 32'h10, 8'h01);
    set_req(1, 1'b1, 32'h14, 8'h02);
    #1;
    tick;
    chk("abandon_grant", grant, 4'b0001);
    host_i[0].a_valid = 1'b0;
    #1;
    chk("abandon_dev_avalid", dev_o.a_valid, 0);
    tick;
    chk("abandon_busy", busy, 0);
    m_last = 0;
    run_txn(1, 0, 0, $urandom, 1'b1);
    // Reset while the host-2 response is pending.
    do_reset;
    set_req(2, 1'b1, 32'h200, 8'h44);
    #1;
    tick;
    dev_i.a_ready = 1'b1;
    tick;
    dev_i.a_ready = 1'b0;
    dev_i.d_valid = 1'b1;
    #1;
    chk("rstrsp_h2_dvalid", host_o[2].d_valid, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    m_last = N - 1;
    idle_zero("rst_in_rsp");
    dev_i = '0;
    set_req(0, 1'b1, 32'h300, 8'h55);
    run_txn(0, 0, 0, $urandom, 1'b1);
    // Randomized request sets checked against the rotation model.
    do_reset;
    for (int t = 0; t < 40; t++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int j = 0; j < N; j++) set_req(j, mask[j], $urandom, 8'($urandom));
      h = model_pick(mask);
      run_txn(h, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
